clk_div: RTL and testbench
==========================

# clk_div

Integer clock divider: derives a slower clock `o_div_clk` from reference clock `i_clk_ref` using a runtime-programmable ratio. When the divider is disabled or the ratio cannot be divided (0 or 1), the output passes the reference clock through. The block sits in the clock-generation area and feeds downstream logic that needs a programmable lower-rate clock, for example a UART baud clock.

## Interface
- `WIDTH`, default 8: width of the ratio input. Supported ratios are 2 .. 2^WIDTH−1.

- `i_clk_ref`, input, 1: reference clock. All state is on the rising edge.
- `i_rst_n`, input, 1: reset. One clock; reset is asynchronous and active-low.
- `i_clk_en`, input, 1: divider enable, synchronous to `i_clk_ref`.
- `i_div_ratio`, input, WIDTH: division ratio N, unsigned.
- `o_div_clk`, output, 1: divided clock, or `i_clk_ref` in bypass.

## Operation
- Internal `div_en` = `i_clk_en` AND (N ≠ 0) AND (N ≠ 1).
- Output mux:
  - `o_div_clk` = `div_reg` when `div_en`=1.
  - `o_div_clk` = `i_clk_ref` otherwise (bypass).
- Phase lengths, in reference cycles:
  - High phase H = floor(N/2).
  - Low phase L = N − H.
  - Even N gives a 50% duty cycle. Odd N has the low phase one cycle longer than the high phase.
- State:
  - Counter `cnt`, WIDTH bits, counts elapsed cycles in the current phase.
  - `div_reg`, 1 bit, holds the current phase.
- On each rising edge with `div_en`=1:
  - If `div_reg`=0 and `cnt` ≥ L−1: set `div_reg`←1 and `cnt`←0.
  - If `div_reg`=1 and `cnt` ≥ H−1: set `div_reg`←0 and `cnt`←0.
  - Otherwise: `cnt`←`cnt`+1.
- On a rising edge with `div_en`=0: `cnt`←0 and `div_reg`←0. Every new enable therefore starts in the low phase from count 0.
- Arithmetic:
  - H and L are computed combinationally from the current `i_div_ratio`.
  - Use the ≥ compare so that lowering N mid-phase ends the phase on the next edge. `cnt` never wraps.

## Timing
- Reset (async assert, `i_rst_n`=0): `cnt`=0 and `div_reg`=0.
  - `o_div_clk` equals `i_clk_ref` if `div_en`=0, otherwise 0.
  - Release is sampled on the next rising edge.
- Start-up: with `div_en` first sampled 1 at rising edge E0, the low phase covers edges E0..E(L−1).
  - `o_div_clk` rises at edge E(L−1)+1, i.e. L cycles after the first enabled edge. Clock-to-Q applies from `i_clk_ref`↑.
  - Thereafter the period is N reference cycles: high for H cycles, low for L cycles.
- Ratio change while enabled takes effect at the next phase-end comparison, with no reset of the counter. The current phase ends no later than the next edge if `cnt` already exceeds the new limit.
- Enable drop or ratio change to 0/1: the mux switches to bypass combinationally, and the state clears on the next edge. A glitch on `o_div_clk` at mux switchover is accepted. Downstream logic must not depend on clean transitions when toggling `i_clk_en` or the ratio.
- Reset mid-operation: `o_div_clk` is immediately forced per the reset rule above, independent of the clock. The division sequence restarts with the low phase after release.
- No handshakes. Inputs are assumed synchronous to `i_clk_ref`.

## Test plan
- Reset with `i_clk_en`=0 and N=0, 4 ns reference period: `o_div_clk` tracks `i_clk_ref` exactly. Internal `div_reg`=0.
- `i_clk_en`=1, N=0 then N=1: `o_div_clk` remains identical to `i_clk_ref` (bypass) in both cases.
- `i_clk_en`=1, N=2: period 8 ns with 4 ns high / 4 ns low. First rising edge one reference cycle after the first enabled edge.
- N=3: period 12 ns with 4 ns high / 8 ns low. N=15: period 60 ns with 28 ns high / 32 ns low.
- Sweep N=0..15, each held for (N+10) reference cycles:
  - For every N ≥ 2, measured period = 4·N ns, high time = 4·floor(N/2) ns.
  - No phase ever exceeds the new ratio's phase length + 1 cycle after a change.
- Assert `i_rst_n`=0 mid-high-phase with N=6: `o_div_clk` falls to 0 asynchronously. After release, the first rising edge comes 3 reference cycles later.

Source files
------------

// File: rtl/clk_div.sv
`timescale 1ns/1ps
// Integer clock divider: o_div_clk = i_clk_ref / N, or i_clk_ref itself when
// disabled or N < 2.
module clk_div #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk_ref,
  input  logic             i_rst_n,
  input  logic             i_clk_en,
  input  logic [WIDTH-1:0] i_div_ratio,
  output logic             o_div_clk
);

  typedef enum logic {
    PH_LOW  = 1'b0,
    PH_HIGH = 1'b1
  } phase_t;

  phase_t           r_phase;
  phase_t           w_phaseNext;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cntNext;
  logic [WIDTH-1:0] w_high;
  logic [WIDTH-1:0] w_low;
  logic             w_divEn;
  logic             w_lowDone;
  logic             w_highDone;

  assign w_divEn = i_clk_en && (i_div_ratio != '0) && (i_div_ratio != WIDTH'(1));
  assign w_high  = i_div_ratio >> 1;
  assign w_low   = i_div_ratio - w_high;

  // >= rather than == so a ratio lowered mid-phase ends the phase on the next edge
  assign w_lowDone  = (r_cnt >= (w_low - WIDTH'(1)));
  assign w_highDone = (r_cnt >= (w_high - WIDTH'(1)));

  always_ff @(posedge i_clk_ref or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase <= PH_LOW;
      r_cnt   <= '0;
    end else begin
      r_phase <= w_phaseNext;
      r_cnt   <= w_cntNext;
    end
  end

  always_comb begin
    w_phaseNext = r_phase;
    w_cntNext   = r_cnt + WIDTH'(1);
    if (!w_divEn) begin
      w_phaseNext = PH_LOW;
      w_cntNext   = '0;
    end else begin
      case (r_phase)
        PH_LOW: begin
          if (w_lowDone) begin
            w_phaseNext = PH_HIGH;
            w_cntNext   = '0;
          end
        end
        PH_HIGH: begin
          if (w_highDone) begin
            w_phaseNext = PH_LOW;
            w_cntNext   = '0;
          end
        end
      endcase
    end
  end

  // Glitches at bypass switchover are tolerated by downstream logic
  assign o_div_clk = w_divEn ? (r_phase == PH_HIGH) : i_clk_ref;

endmodule

// File: tb/tb_clk_div.sv
`timescale 1ns/1ps
// Testbench for clk_div: table of ratio/enable vectors with hand-computed
// periods and high times, plus start-up, ratio-drop and reset sequences.
module tb_clk_div;

  logic       clkRef;
  logic       rstN;
  logic       clkEn;
  logic [7:0] divRatio;
  logic       divClk;

  int checkCount = 0;
  int passCount  = 0;

  // expPeriod of 0 marks a bypass vector
  typedef struct {
    logic       en;
    logic [7:0] ratio;
    int         expPeriod;
    int         expHigh;
  } vec_t;

  vec_t vecs[25];

  clk_div #(.WIDTH(8)) dut (
    .i_clk_ref  (clkRef),
    .i_rst_n    (rstN),
    .i_clk_en   (clkEn),
    .i_div_ratio(divRatio),
    .o_div_clk  (divClk)
  );

  // 4 ns reference period
  initial begin
    clkRef = 1'b0;
    forever #2 clkRef = ~clkRef;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Drives inputs just after a rising edge so they are stable for the next one
  task automatic applyStimulus(input logic en, input logic [7:0] ratio);
    clkEn    = en;
    divRatio = ratio;
  endtask

  // Counts rising edges until the output (sampled 1 ns after each edge) equals level
  task automatic waitLevel(input logic level, input int bound, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < bound) begin
      @(posedge clkRef);
      #1;
      n++;
      if (divClk == level) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic checkBypass(input string name);
    for (int k = 0; k < 2; k++) begin
      @(posedge clkRef);
      #1;
      checkOutput({name, " bypass high"}, int'(divClk), 1);
      @(negedge clkRef);
      #1;
      checkOutput({name, " bypass low"}, int'(divClk), 0);
    end
    @(posedge clkRef);
    #1;
  endtask

  task automatic checkDivided(input string name, input int expPeriod, input int expHigh);
    int  n;
    int  h;
    int  l;
    bit  ok;
    logic prev;
    int  lowLen;
    lowLen = expPeriod - expHigh;
    #0.1;
    prev = divClk;
    waitLevel(~prev, lowLen + 1, n, ok);
    checkOutput({name, " first phase within bound"}, int'(ok), 1);
    waitLevel(1'b0, 2 * expPeriod + 4, n, ok);
    waitLevel(1'b1, 2 * expPeriod + 4, n, ok);
    checkOutput({name, " rise found"}, int'(ok), 1);
    waitLevel(1'b0, expPeriod + 2, h, ok);
    waitLevel(1'b1, expPeriod + 2, l, ok);
    checkOutput({name, " high cycles"}, h, expHigh);
    checkOutput({name, " period cycles"}, h + l, expPeriod);
  endtask

  initial begin
    int  n;
    bit  ok;
    vecs = '{
      '{1'b0, 8'd5,   0,   0},
      '{1'b1, 8'd0,   0,   0},
      '{1'b1, 8'd1,   0,   0},
      '{1'b1, 8'd2,   2,   1},
      '{1'b1, 8'd3,   3,   1},
      '{1'b1, 8'd15,  15,  7},
      '{1'b1, 8'd0,   0,   0},
      '{1'b1, 8'd1,   0,   0},
      '{1'b1, 8'd2,   2,   1},
      '{1'b1, 8'd3,   3,   1},
      '{1'b1, 8'd4,   4,   2},
      '{1'b1, 8'd5,   5,   2},
      '{1'b1, 8'd6,   6,   3},
      '{1'b1, 8'd7,   7,   3},
      '{1'b1, 8'd8,   8,   4},
      '{1'b1, 8'd9,   9,   4},
      '{1'b1, 8'd10,  10,  5},
      '{1'b1, 8'd11,  11,  5},
      '{1'b1, 8'd12,  12,  6},
      '{1'b1, 8'd13,  13,  6},
      '{1'b1, 8'd14,  14,  7},
      '{1'b1, 8'd15,  15,  7},
      '{1'b1, 8'd255, 255, 127},
      '{1'b1, 8'd4,   4,   2},
      '{1'b0, 8'd4,   0,   0}
    };

    // Reset in bypass: output tracks the reference clock
    rstN = 1'b0;
    applyStimulus(1'b0, 8'd0);
    checkBypass("reset en0 N0");

    // Reset with divider enabled: output held at 0 even while clock is high
    applyStimulus(1'b1, 8'd4);
    @(posedge clkRef);
    #1;
    checkOutput("reset en1 N4 high half", int'(divClk), 0);
    @(negedge clkRef);
    #1;
    checkOutput("reset en1 N4 low half", int'(divClk), 0);

    applyStimulus(1'b0, 8'd0);
    @(posedge clkRef);
    #1;
    rstN = 1'b1;
    @(posedge clkRef);
    #1;

    for (int i = 0; i < 25; i++) begin
      string name;
      name = $sformatf("vec%0d N=%0d en=%0d", i, vecs[i].ratio, vecs[i].en);
      applyStimulus(vecs[i].en, vecs[i].ratio);
      if (vecs[i].expPeriod == 0) checkBypass(name);
      else checkDivided(name, vecs[i].expPeriod, vecs[i].expHigh);
      repeat (int'(vecs[i].ratio) + 10) @(posedge clkRef);
      #1;
    end

    // Start-up latency from disabled: rise after L enabled edges
    applyStimulus(1'b0, 8'd2);
    repeat (3) @(posedge clkRef);
    #1;
    applyStimulus(1'b1, 8'd2);
    waitLevel(1'b1, 10, n, ok);
    checkOutput("startup N=2 edges to rise", n, 1);

    applyStimulus(1'b0, 8'd5);
    repeat (3) @(posedge clkRef);
    #1;
    applyStimulus(1'b1, 8'd5);
    waitLevel(1'b1, 10, n, ok);
    checkOutput("startup N=5 edges to rise", n, 3);

    // Lowering N deep into a long low phase ends it on the next edge
    applyStimulus(1'b1, 8'd15);
    waitLevel(1'b1, 40, n, ok);
    waitLevel(1'b0, 40, n, ok);
    checkOutput("N=15 fall found", int'(ok), 1);
    repeat (5) @(posedge clkRef);
    #1;
    checkOutput("N=15 still low", int'(divClk), 0);
    applyStimulus(1'b1, 8'd4);
    waitLevel(1'b1, 10, n, ok);
    checkOutput("ratio drop edges to rise", n, 1);

    // Asynchronous reset in the high phase with N=6
    applyStimulus(1'b1, 8'd6);
    waitLevel(1'b0, 20, n, ok);
    waitLevel(1'b1, 20, n, ok);
    checkOutput("N=6 in high phase", int'(divClk), 1);
    #0.5;
    rstN = 1'b0;
    #0.1;
    checkOutput("async reset forces low", int'(divClk), 0);
    @(negedge clkRef);
    #1;
    checkOutput("reset held low", int'(divClk), 0);
    @(posedge clkRef);
    #1;
    checkOutput("reset held low at high clk", int'(divClk), 0);
    rstN = 1'b1;
    waitLevel(1'b1, 10, n, ok);
    checkOutput("post-reset edges to rise", n, 3);
    waitLevel(1'b0, 10, n, ok);
    checkOutput("post-reset high cycles", n, 3);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
